// File: rtl/wb_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_gpio_pkg
// Description : Register offsets and decode helpers for the Wishbone GPIO
//               peripheral. WB_GPIO_FALL_EDGE_EN adds the fall-status word.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_gpio_pkg;

    typedef logic [2:0] reg_off_t;

    localparam reg_off_t REG_LEDS = 3'd0;
    localparam reg_off_t REG_BTN  = 3'd1;
    localparam reg_off_t REG_RISE = 3'd2;
    localparam reg_off_t REG_MASK = 3'd3;
    localparam reg_off_t REG_FALL = 3'd4;

`ifdef WB_GPIO_FALL_EDGE_EN
    localparam int unsigned NUM_REGS = 5;
`else
    localparam int unsigned NUM_REGS = 4;
`endif

    // Unsigned subtraction wraps addresses below the base out of range.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off < NUM_REGS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_gpio_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_gpio_debounce_if
// Description : Pipelined Wishbone slave port bundle for the GPIO peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_gpio_debounce_if;

    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );

endinterface
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce
// Description : One-bit two-flop synchroniser followed by a stability counter.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_raw,
    output logic      o_db,
    output logic      o_change
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_db;

    // High in the cycle whose clock edge flips the debounced value.
    assign o_change = (r_sync2 != r_db) && (r_cnt == c_cnt_last);
    assign o_db     = r_db;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_db    <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : wb_gpio_debounce
// Description : Wishbone GPIO slave: debounced buttons with W1C edge status
//               and maskable irq, plus an LED register. Optional macro
//               WB_GPIO_FALL_EDGE_EN adds fall-edge status at offset 4.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_gpio_debounce
    import wb_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h00000010,
    parameter int          N_BUTTONS       = 3,
    parameter int          N_LEDS          = 8,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    wb_gpio_debounce_if.slave         wb,
    input  wire logic [N_BUTTONS-1:0] buttons,
    output logic      [N_LEDS-1:0]    leds,
    output logic                      irq
);

    logic [31:0]          w_off;
    reg_off_t             w_sel;
    logic                 w_req;
    logic                 w_wr;
    logic [31:0]          w_rd;
    logic [N_BUTTONS-1:0] w_db;
    logic [N_BUTTONS-1:0] w_chg;
    logic [N_BUTTONS-1:0] w_rise_clr;
    logic                 w_unused_ok;

    logic                 r_ack;
    logic [31:0]          r_rdata;
    logic [N_LEDS-1:0]    r_leds;
    logic [N_BUTTONS-1:0] r_rise;
    logic [N_BUTTONS-1:0] r_mask;
    logic                 r_irq;

    assign w_off      = wb.i_wb_addr - BASE_ADDR;
    assign w_sel      = w_off[2:0];
    assign w_req      = wb.i_wb_cyc && wb.i_wb_stb && addr_hit(wb.i_wb_addr, BASE_ADDR);
    assign w_wr       = w_req && wb.i_wb_we;
    assign w_rise_clr = (w_wr && w_sel == REG_RISE) ? wb.i_wb_data[N_BUTTONS-1:0] : '0;
    // Upper write-data bits beyond each field width are deliberately dropped.
    assign w_unused_ok = &{1'b0, wb.i_wb_data};

    generate
        for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
            gpio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk     (clk),
                .reset   (reset),
                .i_raw   (buttons[i]),
                .o_db    (w_db[i]),
                .o_change(w_chg[i])
            );
        end
    endgenerate

`ifdef WB_GPIO_FALL_EDGE_EN
    logic [N_BUTTONS-1:0] r_fall;
    logic [N_BUTTONS-1:0] w_fall_clr;
    assign w_fall_clr = (w_wr && w_sel == REG_FALL) ? wb.i_wb_data[N_BUTTONS-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fall <= '0;
        end else begin
            r_fall <= (r_fall & ~w_fall_clr) | (w_chg & w_db);
        end
    end
`endif

    always_comb begin
        w_rd = '0;
        case (w_sel)
            REG_LEDS: w_rd = 32'(r_leds);
            REG_BTN:  w_rd = 32'(w_db);
            REG_RISE: w_rd = 32'(r_rise);
            REG_MASK: w_rd = 32'(r_mask);
`ifdef WB_GPIO_FALL_EDGE_EN
            REG_FALL: w_rd = 32'(r_fall);
`endif
            default:  w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_leds  <= '0;
            r_rise  <= '0;
            r_mask  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_req && !wb.i_wb_we) ? w_rd : 32'd0;
            if (w_wr && w_sel == REG_LEDS) r_leds <= wb.i_wb_data[N_LEDS-1:0];
            if (w_wr && w_sel == REG_MASK) r_mask <= wb.i_wb_data[N_BUTTONS-1:0];
            // A new rising edge outranks a simultaneous clear.
            r_rise  <= (r_rise & ~w_rise_clr) | (w_chg & ~w_db);
`ifdef WB_GPIO_FALL_EDGE_EN
            r_irq   <= |((r_rise | r_fall) & r_mask);
`else
            r_irq   <= |(r_rise & r_mask);
`endif
        end
    end

    assign wb.o_wb_ack   = r_ack;
    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_data  = r_rdata;
    assign leds          = r_leds;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_gpio_debounce
// Description : Self-checking bench for wb_gpio_debounce with a cycle-level
//               behavioural model of bus, debounce window and status words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_gpio_debounce;

    localparam logic [31:0] BASE = 32'h00000010;
    localparam int NB = 3;
    localparam int NL = 8;
    localparam int DC = 16;
`ifdef WB_GPIO_FALL_EDGE_EN
    localparam int unsigned NREGS = 5;
`else
    localparam int unsigned NREGS = 4;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] buttons;
    logic [NL-1:0] leds;
    logic          irq;

    always #5 clk = ~clk;

    wb_gpio_debounce_if bus ();

    wb_gpio_debounce #(
        .BASE_ADDR(BASE), .N_BUTTONS(NB), .N_LEDS(NL), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .wb(bus), .buttons(buttons), .leds(leds), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    // Model: synced value is the raw level two edges old; the debounced
    // value flips once the last DC synced samples all disagree with it.
    logic [NB-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_mask;
    logic [NL-1:0] m_leds;
    logic          m_irq, m_ack;
    logic [31:0]   m_data;
    logic [NB-1:0] m_win[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_mask = '0;
        m_leds = '0; m_irq = 1'b0; m_ack = 1'b0; m_data = '0;
        m_win.delete();
        repeat (DC) m_win.push_back('0);
    endtask

    task automatic idle();
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = '0; bus.i_wb_data = '0;
    endtask

    task automatic setbus(input logic cyc, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.i_wb_cyc = cyc; bus.i_wb_stb = 1'b1; bus.i_wb_we = we;
        bus.i_wb_addr = a; bus.i_wb_data = d;
    endtask

    task automatic tick();
        logic [31:0]   off, rd;
        logic          req;
        logic [NB-1:0] dbn, clr_r, clr_f, st;
        logic          flip;
        off = bus.i_wb_addr - BASE;
        req = bus.i_wb_cyc && bus.i_wb_stb && (off < NREGS);
        m_win.push_back(m_s2);
        m_win.delete(0);
        dbn = m_db;
        for (int b = 0; b < NB; b++) begin
            flip = 1'b1;
            foreach (m_win[k]) if (m_win[k][b] == m_db[b]) flip = 1'b0;
            if (flip) dbn[b] = ~m_db[b];
        end
        case (off)
            32'd0:   rd = 32'(m_leds);
            32'd1:   rd = 32'(m_db);
            32'd2:   rd = 32'(m_rise);
            32'd3:   rd = 32'(m_mask);
            32'd4:   rd = 32'(m_fall);
            default: rd = '0;
        endcase
        clr_r = '0; clr_f = '0;
        if (req && bus.i_wb_we) begin
            if (off == 0) m_leds = bus.i_wb_data[NL-1:0];
            if (off == 2) clr_r = bus.i_wb_data[NB-1:0];
            if (off == 3) st = bus.i_wb_data[NB-1:0];
            if (off == 4) clr_f = bus.i_wb_data[NB-1:0];
        end
        m_ack  = req;
        m_data = (req && !bus.i_wb_we) ? rd : 32'd0;
        m_irq  = (NREGS == 5) ? |((m_rise | m_fall) & m_mask) : |(m_rise & m_mask);
        if (req && bus.i_wb_we && off == 3) m_mask = st;
        m_rise = (m_rise & ~clr_r) | (dbn & ~m_db);
        m_fall = (m_fall & ~clr_f) | (~dbn & m_db);
        m_db = dbn;
        m_s2 = m_s1;
        m_s1 = buttons;
        @(posedge clk);
        #1;
        chk("ack", 32'(bus.o_wb_ack), 32'(m_ack));
        chk("rdata", bus.o_wb_data, m_data);
        chk("leds", 32'(leds), 32'(m_leds));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("stall", 32'(bus.o_wb_stall), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic ack);
        setbus(1'b1, 1'b1, a, d);
        tick();
        ack = bus.o_wb_ack;
        idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic ack);
        setbus(1'b1, 1'b0, a, 32'd0);
        tick();
        d = bus.o_wb_data;
        ack = bus.o_wb_ack;
        idle();
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic hold_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic        ack;
        logic [31:0] d;
        int          lat;
        int          hold;

        reset = 1'b1; buttons = '0; idle(); model_reset();
        #1;
        chk("rst_ack", 32'(bus.o_wb_ack), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_data", bus.o_wb_data, 32'd0);
        hold_reset();

        // 1: LED write then read back
        wr(BASE, 32'hFFFF_FFA5, ack);
        chk("t1_wr_ack", 32'(ack), 32'd1);
        chk("t1_leds", 32'(leds), 32'hA5);
        tick();
        chk("t1_ack_drop", 32'(bus.o_wb_ack), 32'd0);
        rd(BASE, d, ack);
        chk("t1_rd_ack", 32'(ack), 32'd1);
        chk("t1_rd_data", d, 32'h0000_00A5);

        // 2: debounce latency; read result trails the db change by one cycle
        buttons = 3'b101;
        setbus(1'b1, 1'b0, BASE + 1, 32'd0);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (lat == 0 && bus.o_wb_data == 32'h5) lat = k;
        end
        idle();
        chk("t2_latency", 32'(lat), 32'(DC + 3));
        wr(BASE + 2, 32'h7, ack);
        buttons = 3'b111;
        wait_ticks(10);
        buttons = 3'b101;
        wait_ticks(30);
        rd(BASE + 1, d, ack);
        chk("t2_glitch_btn", d, 32'h5);
        rd(BASE + 2, d, ack);
        chk("t2_glitch_rise", d, 32'h0);

        // 3: masked rise raises irq, W1C clears it
        wr(BASE + 3, 32'h1, ack);
        buttons = 3'b100;
        wait_ticks(DC + 4);
        wr(BASE + 2, 32'h7, ack);
        buttons = 3'b101;
        wait_ticks(DC + 4);
        rd(BASE + 2, d, ack);
        chk("t3_rise", d, 32'h1);
        chk("t3_irq_set", 32'(irq), 32'd1);
        wr(BASE + 2, 32'h1, ack);
        tick();
        chk("t3_irq_clr", 32'(irq), 32'd0);
        rd(BASE + 2, d, ack);
        chk("t3_rise_clr", d, 32'h0);

        // 4: clear lands on the same edge as the rise
        buttons = 3'b100;
        wait_ticks(DC + 4);
        wr(BASE + 2, 32'h7, ack);
        buttons = 3'b101;
        wait_ticks(DC + 1);
        wr(BASE + 2, 32'h1, ack);
        rd(BASE + 2, d, ack);
        chk("t4_set_wins", d, 32'h1);

        // 5: unmapped / no-cyc accesses, then back-to-back reads
        wr(BASE + 5, 32'hFF, ack);
        chk("t5_unmapped5", 32'(ack), 32'd0);
`ifndef WB_GPIO_FALL_EDGE_EN
        wr(BASE + 4, 32'hFF, ack);
        chk("t5_unmapped4", 32'(ack), 32'd0);
`endif
        setbus(1'b0, 1'b1, BASE, 32'hFF);
        tick();
        chk("t5_nocyc_ack", 32'(bus.o_wb_ack), 32'd0);
        idle();
        chk("t5_leds_kept", 32'(leds), 32'hA5);
        for (int n = 0; n < 4; n++) begin
            setbus(1'b1, 1'b0, BASE + 32'(n), 32'd0);
            tick();
            chk("t5_b2b_ack", 32'(bus.o_wb_ack), 32'd1);
            if (n == 0) chk("t5_b2b_leds", bus.o_wb_data, 32'hA5);
            if (n == 1) chk("t5_b2b_btn", bus.o_wb_data, 32'h5);
        end
        idle();

        // randomized traffic against the model
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                buttons = NB'($urandom);
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 1) == 1)
                setbus($urandom_range(0, 3) != 0, 1'($urandom), BASE - 1 + 32'($urandom_range(0, 6)), $urandom);
            else
                idle();
            tick();
        end
        idle();

        // 6: asynchronous reset drops an in-flight ack
        wr(BASE + 3, 32'h7, ack);
        buttons = 3'b000;
        wait_ticks(DC + 4);
        wr(BASE + 2, 32'h7, ack);
        buttons = 3'b111;
        wait_ticks(DC + 4);
        wr(BASE, 32'h3C, ack);
        chk("t6_irq_pre", 32'(irq), 32'd1);
        setbus(1'b1, 1'b1, BASE, 32'h99);
        tick();
        chk("t6_ack_pre", 32'(bus.o_wb_ack), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_ack_rst", 32'(bus.o_wb_ack), 32'd0);
        chk("t6_leds_rst", 32'(leds), 32'd0);
        chk("t6_irq_rst", 32'(irq), 32'd0);
        idle();
        buttons = '0;
        model_reset();
        hold_reset();

`ifdef WB_GPIO_FALL_EDGE_EN
        buttons = 3'b100;
        wait_ticks(DC + 4);
        buttons = 3'b000;
        wait_ticks(DC + 4);
        rd(BASE + 4, d, ack);
        chk("t6_fall_ack", 32'(ack), 32'd1);
        chk("t6_fall", d, 32'h4);
`else
        rd(BASE + 1, d, ack);
        chk("t6_btn_after_rst", d, 32'h0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
